// File: rtl/branch_resolver.sv
// Branch resolver: holds the committed S/Z/C/V flags, evaluates conditional
// branches against them, and issues a registered PC redirect followed by a flush.
module branch_resolver #(
  parameter int WIDTH        = 16,
  parameter int DISP_W       = 8,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flag_we,
  input  logic              s_in,
  input  logic              z_in,
  input  logic              c_in,
  input  logic              v_in,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [WIDTH-1:0]  br_pc,
  input  logic [DISP_W-1:0] br_disp,
  output logic              redirect_valid,
  output logic [WIDTH-1:0]  redirect_pc,
  output logic              flush,
  output logic [3:0]        flags_q,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic              state_dbg
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  // Handshake: a request transfers on a rising edge where br_valid && br_ready.
  // br_ready depends on state only; the requester must hold its request while
  // br_ready is low.
  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t            state;
  logic [FC_W-1:0]   flush_cnt;
  logic [3:0]        eff;
  logic              cond_true;
  logic              take;
  logic [WIDTH-1:0]  disp_ext;
  logic [WIDTH-1:0]  target;

  // A same-cycle flag write comes from an older instruction, so bypass it.
  always_comb begin
    eff = flag_we ? {s_in, z_in, c_in, v_in} : flags_q;
    cond_true = 1'b0;
    case (br_cond)
      3'd0:    cond_true = 1'b0;
      3'd1:    cond_true = 1'b1;
      3'd2:    cond_true = eff[2];
      3'd3:    cond_true = eff[3] ^ eff[0];
      3'd4:    cond_true = eff[2] | (eff[3] ^ eff[0]);
      3'd5:    cond_true = !eff[2];
      3'd6:    cond_true = eff[1];
      default: cond_true = 1'b0;
    endcase
  end

  assign br_ready  = (state == IDLE);
  assign state_dbg = (state == FLUSH);
  assign take      = br_valid && br_ready && cond_true;
  assign disp_ext  = {{(WIDTH-DISP_W){br_disp[DISP_W-1]}}, br_disp};
  assign target    = br_pc + disp_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      flush_cnt      <= '0;
      flags_q        <= 4'b0000;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      taken_cnt      <= '0;
    end else begin
      redirect_valid <= 1'b0;
      // Flag writes from wrong-path instructions are dropped while flushing.
      if (flag_we && !flush) begin
        flags_q <= {s_in, z_in, c_in, v_in};
      end
      case (state)
        IDLE: begin
          if (take) begin
            redirect_pc    <= target;
            redirect_valid <= 1'b1;
            flush          <= 1'b1;
            flush_cnt      <= FC_W'(FLUSH_CYCLES - 1);
            state          <= FLUSH;
            if (taken_cnt != {CNT_W{1'b1}}) begin
              taken_cnt <= taken_cnt + 1'b1;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state <= IDLE;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          flush <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed vectors, redirect targets checked by a
// queue-based monitor, flag/handshake/counter state checked inline.
module tb_branch_resolver;

  localparam int WIDTH  = 16;
  localparam int DISP_W = 8;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              flag_we;
  logic              s_in, z_in, c_in, v_in;
  logic              br_valid;
  logic              br_ready;
  logic [2:0]        br_cond;
  logic [WIDTH-1:0]  br_pc;
  logic [DISP_W-1:0] br_disp;
  logic              redirect_valid;
  logic [WIDTH-1:0]  redirect_pc;
  logic              flush;
  logic [3:0]        flags_q;
  logic [CNT_W-1:0]  taken_cnt;
  logic              state_dbg;

  logic              sat_br_ready;
  logic              sat_redirect_valid;
  logic [WIDTH-1:0]  sat_redirect_pc;
  logic              sat_flush;
  logic [3:0]        sat_flags_q;
  logic [1:0]        sat_taken_cnt;
  logic              sat_state_dbg;

  logic [WIDTH-1:0]  exp_q[$];
  int                checks;
  int                errors;

  branch_resolver #(.WIDTH(WIDTH), .DISP_W(DISP_W), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
    .s_in(s_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
    .br_pc(br_pc), .br_disp(br_disp),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .flags_q(flags_q), .taken_cnt(taken_cnt), .state_dbg(state_dbg)
  );

  branch_resolver #(.WIDTH(WIDTH), .DISP_W(DISP_W), .FLUSH_CYCLES(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flag_we(flag_we),
    .s_in(s_in), .z_in(z_in), .c_in(c_in), .v_in(v_in),
    .br_valid(br_valid), .br_ready(sat_br_ready), .br_cond(br_cond),
    .br_pc(br_pc), .br_disp(br_disp),
    .redirect_valid(sat_redirect_valid), .redirect_pc(sat_redirect_pc),
    .flush(sat_flush), .flags_q(sat_flags_q), .taken_cnt(sat_taken_cnt),
    .state_dbg(sat_state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor: every redirect pulse must match the oldest queued target.
  always @(negedge clk) begin
    if (rst_n && redirect_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL redirect_unexpected: actual=%h required=no redirect", redirect_pc);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (redirect_pc !== e) begin
          errors++;
          $display("FAIL redirect_pc: actual=%h required=%h", redirect_pc, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic we, input logic [3:0] szcv);
    flag_we = we;
    {s_in, z_in, c_in, v_in} = szcv;
  endtask

  task automatic drive_br(input logic v, input logic [2:0] cond,
                          input logic [WIDTH-1:0] pc, input logic [DISP_W-1:0] disp);
    br_valid = v;
    br_cond  = cond;
    br_pc    = pc;
    br_disp  = disp;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    set_flags(1'b0, 4'b0000);
    drive_br(1'b0, 3'd0, '0, '0);

    #13;
    check("rst_flags", 32'(flags_q), 32'h0);
    check("rst_ready", 32'(br_ready), 32'h1);
    check("rst_redirect_valid", 32'(redirect_valid), 32'h0);
    check("rst_redirect_pc", 32'(redirect_pc), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    check("rst_taken_cnt", 32'(taken_cnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Flag commit, then BLT not taken since S^V = 0
    set_flags(1'b1, 4'b1001);
    step();
    set_flags(1'b0, 4'b0000);
    check("flags_commit", 32'(flags_q), 32'h9);
    drive_br(1'b1, 3'd3, 16'h0010, 8'h05);
    step();
    drive_br(1'b0, 3'd0, '0, '0);
    check("blt_not_taken_rv", 32'(redirect_valid), 32'h0);
    check("blt_not_taken_ready", 32'(br_ready), 32'h1);

    // BE taken with negative displacement
    set_flags(1'b1, 4'b0100);
    step();
    set_flags(1'b0, 4'b0000);
    drive_br(1'b1, 3'd2, 16'h0100, 8'hF0);
    exp_q.push_back(16'h00F0);
    step();
    drive_br(1'b0, 3'd0, '0, '0);
    check("be_rv", 32'(redirect_valid), 32'h1);
    check("be_flush1", 32'(flush), 32'h1);
    check("be_ready1", 32'(br_ready), 32'h0);
    check("be_cnt", 32'(taken_cnt), 32'h1);
    step();
    check("be_rv_pulse", 32'(redirect_valid), 32'h0);
    check("be_flush2", 32'(flush), 32'h1);
    check("be_ready2", 32'(br_ready), 32'h0);
    step();
    check("be_flush_done", 32'(flush), 32'h0);
    check("be_ready_back", 32'(br_ready), 32'h1);

    // Bypass: BNE sees the same-cycle Z=1 and is not taken
    set_flags(1'b1, 4'b0000);
    step();
    check("bypass_clear", 32'(flags_q), 32'h0);
    set_flags(1'b1, 4'b0100);
    drive_br(1'b1, 3'd5, 16'h0200, 8'h04);
    step();
    check("bypass_bne_rv", 32'(redirect_valid), 32'h0);
    check("bypass_bne_flags", 32'(flags_q), 32'h4);
    // Same setup with BE: taken, and the flag write still commits
    set_flags(1'b1, 4'b0000);
    drive_br(1'b0, 3'd0, '0, '0);
    step();
    set_flags(1'b1, 4'b0100);
    drive_br(1'b1, 3'd2, 16'h0200, 8'h04);
    exp_q.push_back(16'h0204);
    step();
    set_flags(1'b0, 4'b0000);
    drive_br(1'b0, 3'd0, '0, '0);
    check("bypass_be_rv", 32'(redirect_valid), 32'h1);
    check("bypass_be_flags", 32'(flags_q), 32'h4);
    check("bypass_be_cnt", 32'(taken_cnt), 32'h2);
    check("sat_cnt_2", 32'(sat_taken_cnt), 32'h2);
    step();
    step();

    // Flag writes ignored during flush; held request accepted in first IDLE cycle
    set_flags(1'b1, 4'b0000);
    step();
    set_flags(1'b0, 4'b0000);
    drive_br(1'b1, 3'd1, 16'h0300, 8'h10);
    exp_q.push_back(16'h0310);
    step();
    set_flags(1'b1, 4'b1111);
    drive_br(1'b1, 3'd1, 16'h0400, 8'h01);
    step();
    check("flush_flags1", 32'(flags_q), 32'h0);
    check("flush_hold_ready1", 32'(br_ready), 32'h0);
    step();
    check("flush_flags2", 32'(flags_q), 32'h0);
    check("flush_hold_ready2", 32'(br_ready), 32'h1);
    check("flush_hold_flush", 32'(flush), 32'h0);
    set_flags(1'b0, 4'b0000);
    exp_q.push_back(16'h0401);
    step();
    drive_br(1'b0, 3'd0, '0, '0);
    check("held_accept_rv", 32'(redirect_valid), 32'h1);
    check("held_accept_cnt", 32'(taken_cnt), 32'h4);
    step();
    step();

    // PC wrap in both directions
    drive_br(1'b1, 3'd1, 16'hFFFE, 8'h03);
    exp_q.push_back(16'h0001);
    step();
    drive_br(1'b0, 3'd0, '0, '0);
    step();
    step();
    drive_br(1'b1, 3'd1, 16'h0000, 8'hFF);
    exp_q.push_back(16'hFFFF);
    step();
    drive_br(1'b0, 3'd0, '0, '0);
    check("wrap_cnt", 32'(taken_cnt), 32'h6);
    check("sat_cnt_3", 32'(sat_taken_cnt), 32'h3);
    step();
    step();

    // Reserved and NEVER codes, with all flags set
    set_flags(1'b1, 4'b1111);
    step();
    set_flags(1'b0, 4'b0000);
    drive_br(1'b1, 3'd7, 16'h0500, 8'h08);
    step();
    check("cond7_rv", 32'(redirect_valid), 32'h0);
    check("cond7_ready", 32'(br_ready), 32'h1);
    drive_br(1'b1, 3'd0, 16'h0500, 8'h08);
    step();
    drive_br(1'b0, 3'd0, '0, '0);
    check("cond0_rv", 32'(redirect_valid), 32'h0);
    check("hold_redirect_pc", 32'(redirect_pc), 32'hFFFF);
    // BC taken on C=1
    drive_br(1'b1, 3'd6, 16'h0600, 8'h02);
    exp_q.push_back(16'h0602);
    step();
    drive_br(1'b0, 3'd0, '0, '0);
    check("bc_rv", 32'(redirect_valid), 32'h1);
    step();
    step();

    // Reset mid-flush
    drive_br(1'b1, 3'd1, 16'h0010, 8'h00);
    exp_q.push_back(16'h0010);
    step();
    drive_br(1'b0, 3'd0, '0, '0);
    check("pre_rst_flush", 32'(flush), 32'h1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_flush", 32'(flush), 32'h0);
    check("midrst_rv", 32'(redirect_valid), 32'h0);
    check("midrst_cnt", 32'(taken_cnt), 32'h0);
    check("midrst_flags", 32'(flags_q), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", 32'(br_ready), 32'h1);
    check("post_rst_flush", 32'(flush), 32'h0);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
